// File: rtl/pzvbus_mc_fifo_pkg.sv
// rtl/pzvbus_mc_fifo_pkg.sv - shared types and width helpers for the multi-channel pzvbus FIFO
//
// Purpose: arbiter state encoding plus the channel-ID and word-count width
//          calculations used by the interface, the top and the arbiter.
// Ports:   none (package).
// Config:  PZVBUS_MC_FIFO_PACKET_LOCK_EN enables packet-locked arbitration (see arbiter).
package pzvbus_mc_fifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // A single channel still needs a 1-bit ID field on the master stream.
  function automatic int calc_ch_width(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int calc_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pzvbus_mc_fifo_if.sv
// rtl/pzvbus_mc_fifo_if.sv - handshake bundle for the multi-channel FIFO (slave streams in, merged master stream out)
//
// Purpose: groups the per-channel slave streams and the merged master stream.
// Signals: i_valid/o_ready/i_payload  - CHANNELS slave streams (channel c at [c*WIDTH +: WIDTH])
//          o_valid/i_ready/o_payload/o_channel - merged master stream with source channel ID
// Modports: slave  - the FIFO's view (accepts slave streams, drives the master stream)
//           master - the environment's view (producers + consumer)
// Config:  PZVBUS_MC_FIFO_PACKET_LOCK_EN makes o_payload[WIDTH-1] a packet "last" marker.
interface pzvbus_mc_fifo_if
  import pzvbus_mc_fifo_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32,
  parameter int CH_W     = calc_ch_width(CHANNELS)
);

  logic [CHANNELS-1:0]       i_valid;
  logic [CHANNELS-1:0]       o_ready;
  logic [CHANNELS*WIDTH-1:0] i_payload;
  logic                      o_valid;
  logic                      i_ready;
  logic [WIDTH-1:0]          o_payload;
  logic [CH_W-1:0]           o_channel;

  modport slave (
    input  i_valid, i_payload, i_ready,
    output o_ready, o_valid, o_payload, o_channel
  );

  modport master (
    output i_valid, i_payload, i_ready,
    input  o_ready, o_valid, o_payload, o_channel
  );

endinterface

// File: rtl/pzbcm_fifo.sv
// rtl/pzbcm_fifo.sv - single-channel synchronous FIFO with flopped flags and any DEPTH >= 2
//
// Purpose: circular buffer, pointers wrap modulo DEPTH (power of two not required).
// Ports:   i_clk, i_rst_n (async active-low), i_clear (sync flush, wins over push/pop),
//          i_push/i_data, i_pop, o_data (head, combinational read),
//          o_count/o_empty/o_almost_full/o_full (flopped),
//          o_nonempty_next (occupancy after the coming edge, for same-cycle arbitration).
// Caller guarantees no push when full and no pop when empty.
module pzbcm_fifo #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int THRESHOLD = DEPTH,
  parameter int COUNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_full,
  output logic               o_nonempty_next
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               empty_q, empty_d;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = i_push && !i_clear;
    do_pop   = i_pop && !i_clear;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + COUNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - COUNT_W'(1);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_W'(DEPTH));
    afull_d = (count_d >= COUNT_W'(THRESHOLD));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is deliberately not reset; contents are invalid until pushed.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= i_data;
  end

  assign o_data          = mem[rd_ptr_q];
  assign o_count         = count_q;
  assign o_empty         = empty_q;
  assign o_full          = full_q;
  assign o_almost_full   = afull_q;
  assign o_nonempty_next = !empty_d;

endmodule

// File: rtl/pzvbus_mc_fifo_arbiter.sv
// rtl/pzvbus_mc_fifo_arbiter.sv - round-robin grant FSM for the multi-channel FIFO
//
// Purpose: owns the round-robin pointer, IDLE/GRANT state, packet lock and the
//          encoded/one-hot grant.
// Ports:   i_clk, i_rst_n (async active-low), i_avail_next (per-channel non-empty
//          after the coming edge), i_clear, i_ready, i_last (lock build only),
//          o_valid, o_grant (encoded), o_pop (one-hot pop strobe).
// Config:  PZVBUS_MC_FIFO_PACKET_LOCK_EN - hold the grant until a beat with last=1 pops.
module pzvbus_mc_fifo_arbiter
  import pzvbus_mc_fifo_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CH_W     = calc_ch_width(CHANNELS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_avail_next,
  input  logic [CHANNELS-1:0] i_clear,
  input  logic                i_ready,
`ifdef PZVBUS_MC_FIFO_PACKET_LOCK_EN
  input  logic                i_last,
`endif
  output logic                o_valid,
  output logic [CH_W-1:0]     o_grant,
  output logic [CHANNELS-1:0] o_pop
);

  arb_state_e      state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic [CH_W-1:0] base, idx, pick;
  logic            pick_found, pop, hold;

  // Round-robin search starts after the last served channel. In GRANT the search
  // is only consulted on a pop, when the pointer is about to become the grant.
  always_comb begin
    base       = (state_q == ARB_GRANT) ? grant_q : ptr_q;
    idx        = base;
    pick       = base;
    pick_found = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CH_W'((int'(base) + i) % CHANNELS);
      if (!pick_found && i_avail_next[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    pop     = valid_q && i_ready;
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    hold    = 1'b0;
    o_pop   = '0;
    if (pop) o_pop[grant_q] = 1'b1;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick;
          valid_d = 1'b1;
        end
      end
      default: begin
        if (i_clear[grant_q]) begin
          // Flushing the granted channel is the only way valid is withdrawn;
          // it also drops any packet lock.
          state_d = ARB_IDLE;
          valid_d = 1'b0;
        end else if (pop) begin
          ptr_d = grant_q;
`ifdef PZVBUS_MC_FIFO_PACKET_LOCK_EN
          hold = !i_last;
`endif
          if (hold) begin
            // Mid-packet: stay on this channel, valid tracks its occupancy.
            valid_d = i_avail_next[grant_q];
          end else if (pick_found) begin
            grant_d = pick;
            valid_d = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          // Stalled or waiting on a locked channel: grant never moves here.
          valid_d = i_avail_next[grant_q];
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= CH_W'(CHANNELS - 1);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_grant = grant_q;

endmodule

// File: rtl/pzvbus_mc_fifo.sv
// rtl/pzvbus_mc_fifo.sv - CHANNELS slave streams, each in its own FIFO, merged round-robin onto one master stream
//
// Purpose: per-channel buffering plus round-robin merge tagged with source channel ID.
// Ports:   i_clk, i_rst_n (async active-low), i_clear (per-channel sync flush),
//          bus (pzvbus_mc_fifo_if.slave: slave streams in, merged stream out),
//          o_empty/o_almost_full/o_full (per channel), o_word_count (COUNT_W per channel).
// Config:  PZVBUS_MC_FIFO_PACKET_LOCK_EN - payload bit WIDTH-1 is "last"; grant is held per packet.
module pzvbus_mc_fifo
  import pzvbus_mc_fifo_pkg::*;
#(
  parameter  int CHANNELS  = 4,
  parameter  int DEPTH     = 8,
  parameter  int WIDTH     = 32,
  parameter  int THRESHOLD = DEPTH,
  localparam int CH_W      = calc_ch_width(CHANNELS),
  localparam int COUNT_W   = calc_count_width(DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [CHANNELS-1:0]         i_clear,
  pzvbus_mc_fifo_if.slave             bus,
  output logic [CHANNELS-1:0]         o_empty,
  output logic [CHANNELS-1:0]         o_almost_full,
  output logic [CHANNELS-1:0]         o_full,
  output logic [CHANNELS*COUNT_W-1:0] o_word_count
);

  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] pop;
  logic [CHANNELS-1:0] avail_next;
  logic [WIDTH-1:0]    head [CHANNELS];
  logic [CH_W-1:0]     grant;

  assign bus.o_ready = ~o_full & ~i_clear;
  assign push        = bus.i_valid & bus.o_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    pzbcm_fifo #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .THRESHOLD (THRESHOLD),
      .COUNT_W   (COUNT_W)
    ) u_fifo (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_clear         (i_clear[c]),
      .i_push          (push[c]),
      .i_data          (bus.i_payload[c*WIDTH +: WIDTH]),
      .i_pop           (pop[c]),
      .o_data          (head[c]),
      .o_count         (o_word_count[c*COUNT_W +: COUNT_W]),
      .o_empty         (o_empty[c]),
      .o_almost_full   (o_almost_full[c]),
      .o_full          (o_full[c]),
      .o_nonempty_next (avail_next[c])
    );
  end

  pzvbus_mc_fifo_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_arbiter (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_avail_next (avail_next),
    .i_clear      (i_clear),
    .i_ready      (bus.i_ready),
`ifdef PZVBUS_MC_FIFO_PACKET_LOCK_EN
    .i_last       (bus.o_payload[WIDTH-1]),
`endif
    .o_valid      (bus.o_valid),
    .o_grant      (grant),
    .o_pop        (pop)
  );

  // Grant only changes on pop or clear, so the head mux is stable during a stall.
  assign bus.o_payload = head[grant];
  assign bus.o_channel = grant;

endmodule
